// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioning path: board clock,
// default debounce window and the debounce FSM state encoding.
package btn_debounce_pulse_pkg;

  localparam int unsigned CLK_HZ = 32'd50_000_000;
  localparam int unsigned DEBOUNCE_MS = 32'd10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } state_e;

  // Debounced level implied by a state: high while accepted-pressed or qualifying a release.
  function automatic logic state_level(input state_e s);
    logic lvl;
    case (s)
      IDLE_LO: lvl = 1'b0;
      CHK_HI:  lvl = 1'b0;
      IDLE_HI: lvl = 1'b1;
      CHK_LO:  lvl = 1'b1;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; only the second stage is safe to use downstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button into a registered level plus one-cycle
// press/release strobes, all on a single clock.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

  logic                 btn_sync_s;
  state_e               state_d, state_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 btn_level_d, btn_level_q;
  logic                 btn_pulse_d, btn_pulse_q;
  logic                 btn_release_pulse_d, btn_release_pulse_q;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn_in),
    .q    (btn_sync_s)
  );

  // Next-state, counter and strobe logic; any disagreeing sample restarts qualification.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    btn_pulse_d         = 1'b0;
    btn_release_pulse_d = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (btn_sync_s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!btn_sync_s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE_HI;
          cnt_d       = '0;
          btn_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!btn_sync_s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (btn_sync_s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d             = IDLE_LO;
          cnt_d               = '0;
          btn_release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
    btn_level_d = state_level(state_d);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q             <= IDLE_LO;
      cnt_q               <= '0;
      btn_level_q         <= 1'b0;
      btn_pulse_q         <= 1'b0;
      btn_release_pulse_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      btn_level_q         <= btn_level_d;
      btn_pulse_q         <= btn_pulse_d;
      btn_release_pulse_q <= btn_release_pulse_d;
    end
  end

  assign btn_level         = btn_level_q;
  assign btn_pulse         = btn_pulse_q;
  assign btn_release_pulse = btn_release_pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed self-checking bench for btn_debounce_pulse with a 4-cycle window.
module tb_btn_debounce_pulse;

  logic clk;
  logic rstn;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_release_pulse;

  int checks   = 0;
  int failures = 0;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .btn_in            (btn_in),
    .btn_level         (btn_level),
    .btn_pulse         (btn_pulse),
    .btn_release_pulse (btn_release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic l, input logic p, input logic r);
    chk({tag, ".level"}, btn_level, l);
    chk({tag, ".pulse"}, btn_pulse, p);
    chk({tag, ".release"}, btn_release_pulse, r);
  endtask

  // Drive a new level and expect acceptance exactly after edge E0+5.
  task automatic qualify(input logic v, input string tag);
    btn_in = v;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_out({tag, ".wait"}, ~v, 1'b0, 1'b0);
    end
    step(1);
    chk_out({tag, ".accept"}, v, v, ~v);
    step(1);
    chk_out({tag, ".after"}, v, 1'b0, 1'b0);
  endtask

  initial begin
    rstn   = 1'b0;
    btn_in = 1'b1;
    #2;
    chk_out("reset_async", 1'b0, 1'b0, 1'b0);
    step(3);
    chk_out("reset_held", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    qualify(1'b1, "reset_release_press");

    qualify(1'b0, "release1");

    qualify(1'b1, "clean_press");
    for (int i = 0; i < 14; i++) begin
      step(1);
      chk_out("hold", 1'b1, 1'b0, 1'b0);
    end
    qualify(1'b0, "release2");

    btn_in = 1'b1; step(1); chk_out("bounce0", 1'b0, 1'b0, 1'b0);
    btn_in = 1'b0; step(1); chk_out("bounce1", 1'b0, 1'b0, 1'b0);
    btn_in = 1'b1; step(1); chk_out("bounce2", 1'b0, 1'b0, 1'b0);
    btn_in = 1'b1; step(1); chk_out("bounce3", 1'b0, 1'b0, 1'b0);
    btn_in = 1'b0; step(1); chk_out("bounce4", 1'b0, 1'b0, 1'b0);
    qualify(1'b1, "bounce_press");
    qualify(1'b0, "release3");

    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_out("glitch", 1'b0, 1'b0, 1'b0);
    end

    btn_in = 1'b1;
    step(3);
    #3;
    rstn = 1'b0;
    #1;
    chk_out("rst_mid_chk", 1'b0, 1'b0, 1'b0);
    step(2);
    chk_out("rst_mid_chk_held", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    qualify(1'b1, "requalify");

    #3;
    rstn = 1'b0;
    #1;
    chk_out("rst_idle_hi", 1'b0, 1'b0, 1'b0);
    step(1);
    rstn   = 1'b1;
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk_out("post_rst_low", 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw, bouncy push-button input from the board into a clean level and single-cycle event strobes.
- Sits directly upstream of the 3-state Moore sequencer. That sequencer advances on a rising edge of its step input, so `btn_level` is the signal that drives it.
- `btn_pulse` and `btn_release_pulse` serve consumers that run on the same clock.
- All logic is on one clock; no combinational path from `btn_in` to any output.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-sample count required to accept a new level (10 ms at 50 MHz); must be >= 2.
- CNT_WIDTH, 19, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- btn_in  input  1  raw button, active-high, asynchronous to clk, may bounce
- btn_level  output  1  debounced button level, registered
- btn_pulse  output  1  one-cycle strobe on accepted press (0->1 of btn_level)
- btn_release_pulse  output  1  one-cycle strobe on accepted release (1->0 of btn_level)

Behaviour:
- Reset: rstn low asynchronously clears both synchronizer flops, the counter, and state (-> IDLE_LO). It also drives btn_level, btn_pulse and btn_release_pulse to 0.
- Reset release mid-bounce restarts qualification from IDLE_LO; no pulse is emitted because of reset.
- Synchronizer: two flops, sync1 <= btn_in, sync2 <= sync1. Only sync2 is used internally.
- State machine, four states:
  - IDLE_LO: btn_level=0, cnt=0. If sync2=1, go to CHK_HI with cnt=1.
  - CHK_HI: btn_level=0.
    - If sync2=0, return to IDLE_LO with cnt=0. Any bounce restarts the count.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_HI, set btn_level=1, pulse btn_pulse for 1 cycle.
    - Else cnt++.
  - IDLE_HI: btn_level=1, cnt=0. If sync2=0, go to CHK_LO with cnt=1.
  - CHK_LO: btn_level=1.
    - If sync2=1, return to IDLE_HI with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_LO, set btn_level=0, pulse btn_release_pulse for 1 cycle.
    - Else cnt++.
  - Unreachable encodings: go to IDLE_LO with all outputs 0.
- Latency: let edge E0 be the first rising clk edge that samples btn_in=1. If btn_in is held, btn_level and btn_pulse rise after edge E0+DEBOUNCE_CYCLES+1. Release is symmetric.
- btn_pulse and btn_release_pulse are never high simultaneously and are never high for two consecutive cycles.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- The counter never wraps: it is bounded by DEBOUNCE_CYCLES-1, and the parameter rule guarantees fit.
- Button held indefinitely: remains in IDLE_HI, exactly one btn_pulse emitted.

Decomposition:
- Shared package holds the state encodings (IDLE_LO=2'b00, CHK_HI=2'b01, IDLE_HI=2'b10, CHK_LO=2'b11) and the board clock constant CLK_HZ=50000000. Default DEBOUNCE_CYCLES derives from CLK_HZ.
- One natural sub-module: sync_2ff, a two-flop synchronizer with async active-low reset (clk, rstn, d, q). It is reusable for other board inputs.
- FSM and counter stay in btn_debounce_pulse.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset: rstn=0 with btn_in=1, then release -> outputs 0 during reset. After release, btn_level rises after edge E0+5, btn_pulse=1 for exactly one cycle.
- Clean press: btn_in 0->1 held for 20 cycles -> btn_level=1 after edge E0+5; btn_pulse high one cycle; btn_release_pulse stays 0.
- Bounce: btn_in toggles 1,0,1,1,0 (one cycle each), then 1 held -> no output change during the toggles. btn_level rises 5 edges after the final stable-1 sample.
- Short glitch: btn_in=1 for 3 cycles then 0 -> btn_level, btn_pulse and btn_release_pulse all remain 0.
- Release: from IDLE_HI, btn_in=0 held -> btn_level falls after edge E0+5; btn_release_pulse high one cycle.
- Async reset mid-CHK_HI: rstn asserted between clk edges -> all outputs 0 immediately. After release with btn_in=1 held, full 5-edge qualification is required again.
